// File: rtl/uart_tx_param.sv
// uart_tx_param -- parameterised UART transmitter with a one-entry holding register.
// Frame: start(0), DATA_BITS data bits LSB first, optional parity, STOP_BITS stop bits(1).
// A word offered while a frame is on the line is parked in the holding register and
// launched on the cycle after the final stop bit, so frames run back to back.
`timescale 1ns/1ps
module uart_tx_param #(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_L,
  input  logic                 i_Tx_DV,
  input  logic [DATA_BITS-1:0] i_Tx_Byte,
  output logic                 o_Tx_Ready,
  output logic                 o_Tx_Active,
  output logic                 o_Tx_Serial,
  output logic                 o_Tx_Done
);

  // Counter widths: cycle counter holds CLKS_PER_BIT-1, bit counter holds max(DATA_BITS, STOP_BITS).
  localparam int LP_CNT_W   = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int LP_BIT_MAX = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
  localparam int LP_BIT_W   = $clog2(LP_BIT_MAX + 1);

  localparam logic [LP_CNT_W-1:0] LP_CLK_LAST  = LP_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [LP_BIT_W-1:0] LP_DATA_LAST = LP_BIT_W'(DATA_BITS - 1);
  localparam logic [LP_BIT_W-1:0] LP_STOP_LAST = LP_BIT_W'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  // Reject illegal configurations at elaboration time.
  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_cpb
    $error("uart_tx_param: CLKS_PER_BIT must be 2..65535");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_tx_param: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end

  // Parity bit for a word: odd parity makes the total count of ones odd, even makes it even.
  function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
    return (PARITY == 1) ? ~(^d) : (^d);
  endfunction

  logic [2:0]           r_state;
  logic [LP_CNT_W-1:0]  r_clk_cnt;
  logic [LP_BIT_W-1:0]  r_bit_cnt;
  logic                 r_serial;
  logic                 r_hold_full;
  logic [DATA_BITS-1:0] r_hold;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par;

  logic                 w_bit_end;
  logic                 w_frame_end;
  logic                 w_xfer;
  logic                 w_load_new;
  logic                 w_load_hold;
  logic                 w_capture;
  logic [DATA_BITS-1:0] w_load_data;

  // w_frame_end marks the last cycle of the final stop bit; that is the handover point
  // where a held word (or a word offered right then) starts with no idle gap.
  assign w_bit_end   = (r_clk_cnt == LP_CLK_LAST);
  assign w_frame_end = (r_state == S_STOP) && w_bit_end && (r_bit_cnt == LP_STOP_LAST);
  assign w_xfer      = i_Tx_DV && !r_hold_full;
  assign w_load_new  = w_xfer && ((r_state == S_IDLE) || w_frame_end);
  assign w_load_hold = w_frame_end && r_hold_full;
  assign w_capture   = w_xfer && !w_load_new;
  assign w_load_data = w_load_hold ? r_hold : i_Tx_Byte;

  assign o_Tx_Ready  = !r_hold_full;
  assign o_Tx_Active = (r_state != S_IDLE);
  assign o_Tx_Serial = r_serial;
  assign o_Tx_Done   = w_frame_end;

  // Frame sequencer: state, bit timing counters and the registered line level.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_state   <= S_IDLE;
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
      r_serial  <= 1'b1;
    end else if (w_load_new || w_load_hold) begin
      r_state   <= S_START;
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
      r_serial  <= 1'b0;
    end else if (r_state != S_IDLE) begin
      if (!w_bit_end) begin
        r_clk_cnt <= r_clk_cnt + 1'b1;
      end else begin
        r_clk_cnt <= '0;
        case (r_state)
          S_START: begin
            r_state   <= S_DATA;
            r_bit_cnt <= '0;
            r_serial  <= r_shift[0];
          end
          S_DATA: begin
            if (r_bit_cnt == LP_DATA_LAST) begin
              r_bit_cnt <= '0;
              if (PARITY != 0) begin
                r_state  <= S_PARITY;
                r_serial <= r_par;
              end else begin
                r_state  <= S_STOP;
                r_serial <= 1'b1;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
              r_serial  <= r_shift[1];
            end
          end
          S_PARITY: begin
            r_state   <= S_STOP;
            r_bit_cnt <= '0;
            r_serial  <= 1'b1;
          end
          S_STOP: begin
            if (r_bit_cnt == LP_STOP_LAST) begin
              r_state   <= S_IDLE;
              r_bit_cnt <= '0;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
            r_serial <= 1'b1;
          end
          default: begin
            r_state   <= S_IDLE;
            r_bit_cnt <= '0;
            r_serial  <= 1'b1;
          end
        endcase
      end
    end
  end

  // Holding-register occupancy; reset discards any parked word.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_hold_full <= 1'b0;
    end else if (w_capture) begin
      r_hold_full <= 1'b1;
    end else if (w_load_hold) begin
      r_hold_full <= 1'b0;
    end
  end

  // Data path: parked word, shift register and precomputed parity (no reset needed).
  always_ff @(posedge i_Clock) begin
    if (w_capture) begin
      r_hold <= i_Tx_Byte;
    end
    if (w_load_new || w_load_hold) begin
      r_shift <= w_load_data;
      r_par   <= parity_of(w_load_data);
    end else if (r_state == S_DATA && w_bit_end && r_bit_cnt != LP_DATA_LAST) begin
      r_shift <= {1'b0, r_shift[DATA_BITS-1:1]};
    end
  end

endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 Parameter CLKS_PER_BIT, default 87, meaning clock cycles per serial bit; legal range 2 to 65535.
REQ-002 Parameter DATA_BITS, default 8, meaning data bits per frame; legal range 5 to 9.
REQ-003 Parameter PARITY, default 0, meaning 0 = none, 1 = odd, 2 = even; value 3 is illegal.
REQ-004 Parameter STOP_BITS, default 1, meaning stop bits per frame; legal values 1 or 2.
REQ-005 i_Clock  input  1  meaning the single clock; all state updates on its rising edge.
REQ-006 i_Rst_L  input  1  meaning reset, asynchronous and active-low.
REQ-007 i_Tx_DV  input  1  meaning the word on i_Tx_Byte is valid this cycle.
REQ-008 i_Tx_Byte  input  DATA_BITS  meaning the data word, transmitted LSB first.
REQ-009 o_Tx_Ready  output  1  meaning the block accepts i_Tx_DV this cycle.
REQ-010 o_Tx_Active  output  1  meaning a frame is on the line.
REQ-011 o_Tx_Serial  output  1  meaning the serial line; idle level is 1.
REQ-012 o_Tx_Done  output  1  meaning a one-cycle pulse at end of frame.

Function
REQ-013 The block SHALL use states IDLE, START, DATA, PARITY, STOP; PARITY SHALL be skipped when PARITY=0.
REQ-014 Each bit SHALL last exactly CLKS_PER_BIT cycles.
REQ-015 Frame order SHALL be: start (0); DATA_BITS data bits, LSB first; optional parity bit; STOP_BITS stop bits (1).
REQ-016 Parity SHALL be computed over the DATA_BITS of the word; odd gives an odd count of ones including the parity bit, even gives an even count.
REQ-017 A one-entry holding register SHALL exist; o_Tx_Ready = 1 iff the holding register is empty.
REQ-018 A transfer SHALL occur only when i_Tx_DV=1 and o_Tx_Ready=1 on the same rising edge; i_Tx_DV while o_Tx_Ready=0 SHALL be ignored, with no state change.
REQ-019 A transfer in IDLE SHALL load the shift register directly, and o_Tx_Serial SHALL go 0 on the following cycle (latency 1); the holding register SHALL stay empty.
REQ-020 A transfer while a frame is active SHALL capture the word into the holding register; o_Tx_Ready SHALL go 0 the next cycle.
REQ-021 On the last cycle of the final stop bit, o_Tx_Done SHALL pulse high for exactly one cycle.
REQ-022 On that same last cycle, if the holding register is full, its word SHALL move to the shift register and START SHALL begin next cycle with no idle gap; o_Tx_Ready SHALL return to 1 next cycle.
REQ-023 On that same last cycle, if the holding register is empty and a transfer occurs, the new word SHALL start next cycle with no idle gap.
REQ-024 Otherwise the block SHALL enter IDLE after the final stop bit.
REQ-025 o_Tx_Active SHALL be 1 in START, DATA, PARITY and STOP, and 0 in IDLE.
REQ-026 The bit counter SHALL be sized to hold max(DATA_BITS, STOP_BITS); the cycle counter SHALL be sized to hold CLKS_PER_BIT-1 without wrap.

Reset
REQ-027 Asserting i_Rst_L=0 SHALL immediately force: IDLE; o_Tx_Serial=1; o_Tx_Active=0; o_Tx_Done=0; o_Tx_Ready=1; holding register empty; counters 0.
REQ-028 Reset mid-frame SHALL abort the frame and discard the held word, with no o_Tx_Done pulse.
REQ-029 After deassertion, the first transfer SHALL be accepted on the first rising edge with i_Rst_L=1.

Verification
REQ-030 Config 87/8/none/1, 100 ns clock, send 0xAB -> line reads 0,1,1,0,1,0,1,0,1,1, each bit 8700 ns; o_Tx_Done pulses once, 870 cycles after serial falls.
REQ-031 PARITY=2, send 0xAB -> parity bit 1; PARITY=1 -> parity bit 0; frame is 11 bits.
REQ-032 DATA_BITS=7, STOP_BITS=2, send 7'h55 -> line reads 0,1,0,1,0,1,0,1,1,1; frame is 10 bits.
REQ-033 Send 0xAB, then 0xCD at cycle 10 -> o_Tx_Ready goes 0; 0xCD start bit begins the cycle after the first o_Tx_Done; a third DV while Ready=0 is ignored.
REQ-034 Pulse i_Rst_L low during data bit 3 -> o_Tx_Serial=1 and o_Tx_Ready=1 immediately; no o_Tx_Done; the next 0x3C is sent correctly.
REQ-035 Hold i_Tx_DV=1 continuously with 0x00 -> back-to-back frames with no idle bit between stop and start.
